// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   lsu_state_t   : control FSM states (IDLE, ACCESS, DONE)
//   F3_*          : func3 encodings for the supported access sizes
//   access_legal  : size/alignment legality of a request
//   byte_enables  : lane enables for a size at a byte offset
//   store_lanes   : store data replicated across the word lanes
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned sizes exist only for loads.
  function automatic logic access_legal(input logic       is_store,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    case (f3)
      F3_B:    return 1'b1;
      F3_H:    return ~off[0];
      F3_W:    return (off == 2'b00);
      F3_BU:   return ~is_store;
      F3_HU:   return ~is_store & ~off[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] f3,
                                              input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: return 4'b0001 << off;
      F3_H, F3_HU: return off[1] ? 4'b1100 : 4'b0011;
      F3_W:        return 4'b1111;
      default:     return 4'b0000;
    endcase
  endfunction

  // Replicating the right-aligned data lets the byte enables alone pick
  // the destination lane, so no shifter is needed on the store path.
  function automatic logic [31:0] store_lanes(input logic [2:0]  f3,
                                              input logic [31:0] d);
    case (f3)
      F3_B:    return {4{d[7:0]}};
      F3_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Load data alignment for the MEM-stage LSU (purely combinational).
// Ports:
//   bus_rdata : raw word returned by the data bus
//   offset    : byte offset of the access within the word
//   func3     : access size / signedness
//   data      : selected byte/halfword/word, sign- or zero-extended
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] bus_rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  func3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = bus_rdata[7:0];
    case (offset)
      2'd0: byte_sel = bus_rdata[7:0];
      2'd1: byte_sel = bus_rdata[15:8];
      2'd2: byte_sel = bus_rdata[23:16];
      2'd3: byte_sel = bus_rdata[31:24];
      default: byte_sel = bus_rdata[7:0];
    endcase
    half_sel = offset[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  end

  always_comb begin
    data = bus_rdata;
    case (func3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = bus_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit. Takes the EX/MEM request, runs one access on
// a word-wide bus with wait states, and returns extended load data.
// The pipeline is frozen through mem_stall from the request cycle until
// the bus acknowledges; the DONE cycle lets the pipeline advance without
// re-issuing the still-visible request.
//
// Optional build macro: LSU_TIMEOUT_EN -- abort an access that has not
// been acknowledged within TIMEOUT_CYC cycles (fault + rd_data cleared).
//
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   mem_read, mem_write   : load / store request (store wins if both)
//   addr, wr_data, func3  : byte address, right-aligned store data, size
//   rd_data               : extended load result (held between loads)
//   mem_stall             : pipeline freeze
//   access_fault          : one-cycle pulse on illegal access or timeout
//   bus_req, bus_we       : bus request / write
//   bus_addr, bus_wdata   : word address, lane-replicated store data
//   bus_be                : byte enables
//   bus_rdata, bus_ack    : bus read data / access complete
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
`ifdef LSU_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            func3,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  mem_stall,
  output logic                  access_fault,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [DM_ADDRESS-1:0] bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [3:0]            bus_be,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_ack
);

  lsu_state_t        state, state_next;
  logic [2:0]        func3_q;
  logic [1:0]        offset_q;
  logic              req;
  logic              is_store;
  logic              legal;
  logic              start;
  logic              fault_idle;
  logic              timeout;
  logic [DATA_W-1:0] load_ext;

  assign req      = mem_read | mem_write;
  assign is_store = mem_write;
  assign legal    = access_legal(is_store, func3, addr[1:0]);

`ifdef LSU_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // bus_ack in the terminal cycle takes precedence over the abort.
  assign timeout = (state == ACCESS) && !bus_ack &&
                   (wait_cnt == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (start) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !bus_ack) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  lsu_load_align u_load_align (
    .bus_rdata (bus_rdata),
    .offset    (offset_q),
    .func3     (func3_q),
    .data      (load_ext)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_stall  = 1'b0;
    bus_req    = 1'b0;
    start      = 1'b0;
    fault_idle = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (legal) begin
            mem_stall  = 1'b1;
            start      = 1'b1;
            state_next = ACCESS;
          end else begin
            fault_idle = 1'b1;
          end
        end
      end
      ACCESS: begin
        bus_req   = 1'b1;
        mem_stall = 1'b1;
        if (bus_ack || timeout) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // The finished instruction is still on the inputs here; going
        // straight back to IDLE keeps it from being issued twice.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data      <= '0;
      access_fault <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_be       <= '0;
      func3_q      <= '0;
      offset_q     <= '0;
    end else begin
      access_fault <= 1'b0;

      if (start) begin
        bus_addr  <= {addr[DM_ADDRESS-1:2], 2'b00};
        bus_we    <= is_store;
        bus_be    <= byte_enables(func3, addr[1:0]);
        bus_wdata <= is_store ? store_lanes(func3, wr_data) : '0;
        func3_q   <= func3;
        offset_q  <= addr[1:0];
      end

      if (fault_idle) begin
        access_fault <= 1'b1;
        if (!is_store) begin
          rd_data <= '0;
        end
      end

      if (state == ACCESS) begin
        if (bus_ack) begin
          if (!bus_we) begin
            rd_data <= load_ext;
          end
        end else if (timeout) begin
          access_fault <= 1'b1;
          if (!bus_we) begin
            rd_data <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [8:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [2:0]  func3 = '0;
  logic [31:0] rd_data;
  logic        mem_stall;
  logic        access_fault;
  logic        bus_req;
  logic        bus_we;
  logic [8:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] slave_mem [128];
  logic [7:0]  ref_bytes [512];
  logic [31:0] exp_rd = '0;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .addr         (addr),
    .wr_data      (wr_data),
    .func3        (func3),
    .rd_data      (rd_data),
    .mem_stall    (mem_stall),
    .access_fault (access_fault),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_be       (bus_be),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack)
  );

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit is_legal(input bit st, input logic [2:0] f3, input logic [8:0] a);
    int sz;
    sz = size_of(f3);
    if (sz == 0) return 1'b0;
    if (st && f3[2]) return 1'b0;
    return (int'(a) % sz) == 0;
  endfunction

  task automatic preload(input int widx, input logic [31:0] v);
    slave_mem[widx] = v;
    for (int i = 0; i < 4; i++) ref_bytes[widx*4 + i] = v[8*i +: 8];
  endtask

  // One complete pipeline access; the request stays on the inputs while
  // stalled and through the release cycle, then is removed.
  task automatic run_access(input bit rd, input bit wr, input logic [8:0] a,
                            input logic [31:0] d, input logic [2:0] f3,
                            input int waits, input string tag);
    bit          st, lg, e_to, fin;
    int          sz, n_stall, n_req, n_flt, acc, e_stall, e_req;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_load;
    st = wr;
    lg = is_legal(st, f3, a);
    sz = size_of(f3);
    e_to = 1'b0;
`ifdef LSU_TIMEOUT_EN
    e_to = lg && (waits >= 16);
`endif
    e_be = '0;
    e_load = '0;
    if (lg) begin
      for (int i = 0; i < sz; i++) begin
        e_be[int'(a[1:0]) + i] = 1'b1;
        e_load[8*i +: 8] = ref_bytes[int'(a) + i];
      end
      if (!f3[2] && sz == 1 && e_load[7])  e_load[31:8]  = '1;
      if (!f3[2] && sz == 2 && e_load[15]) e_load[31:16] = '1;
    end
    e_wd = (sz == 1) ? {4{d[7:0]}} : (sz == 2) ? {2{d[15:0]}} : d;
    e_stall = !lg ? 0 : e_to ? 17 : waits + 2;
    e_req   = !lg ? 0 : e_to ? 16 : waits + 1;
    n_stall = 0; n_req = 0; n_flt = 0; acc = 0; fin = 1'b0;

    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wr_data = d; func3 = f3;
    for (int c = 0; c < 100 && !fin; c++) begin
      #1;
      if (mem_stall) n_stall++;
      if (access_fault) n_flt++;
      if (bus_req) begin
        n_req++;
        n_checks++;
        if (bus_addr !== {a[8:2], 2'b00} || bus_we !== st || bus_be !== e_be ||
            (st && bus_wdata !== e_wd)) begin
          n_fail++;
          $display("FAIL %s bus_fields: got addr=%h we=%b be=%b wdata=%h, want addr=%h we=%b be=%b wdata=%h",
                   tag, bus_addr, bus_we, bus_be, bus_wdata, {a[8:2], 2'b00}, st, e_be, e_wd);
        end
        if (acc == waits) begin
          bus_ack = 1'b1;
          bus_rdata = slave_mem[bus_addr[8:2]];
          if (bus_we)
            for (int i = 0; i < 4; i++)
              if (bus_be[i]) slave_mem[bus_addr[8:2]][8*i +: 8] = bus_wdata[8*i +: 8];
        end else begin
          bus_ack = 1'b0;
          bus_rdata = $urandom;
        end
        acc++;
      end else begin
        bus_ack = 1'b0;
        bus_rdata = $urandom;
      end
      if (!mem_stall) fin = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!fin) begin
      n_fail++;
      $display("FAIL %s stall_release: mem_stall still high after 100 cycles", tag);
    end
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
    #1;
    if (access_fault) n_flt++;

    if (!st) exp_rd = (!lg || e_to) ? 32'd0 : e_load;
    if (st && lg && !e_to)
      for (int i = 0; i < sz; i++) ref_bytes[int'(a) + i] = d[8*i +: 8];

    n_checks++;
    if (rd_data !== exp_rd) begin
      n_fail++;
      $display("FAIL %s rd_data: got %h want %h", tag, rd_data, exp_rd);
    end
    @(negedge clk);
    #1;
    if (access_fault) n_flt++;

    n_checks++;
    if (n_stall !== e_stall) begin
      n_fail++;
      $display("FAIL %s stall_cycles: got %0d want %0d", tag, n_stall, e_stall);
    end
    n_checks++;
    if (n_req !== e_req) begin
      n_fail++;
      $display("FAIL %s req_cycles: got %0d want %0d", tag, n_req, e_req);
    end
    n_checks++;
    if (n_flt !== ((!lg || e_to) ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s fault_pulses: got %0d want %0d", tag, n_flt, (!lg || e_to) ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({rd_data, bus_req, bus_we, bus_be, bus_addr, bus_wdata, access_fault, mem_stall} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got rd=%h req=%b we=%b be=%b addr=%h wdata=%h flt=%b stall=%b, want all 0",
               rd_data, bus_req, bus_we, bus_be, bus_addr, bus_wdata, access_fault, mem_stall);
    end
    reset = 1'b1;
  endtask

  task automatic test_store_word();
    run_access(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, F3_W, 0, "sw_0x010");
  endtask

  task automatic test_store_byte_waits();
    run_access(1'b0, 1'b1, 9'h013, 32'h000000A5, F3_B, 3, "sb_0x013");
  endtask

  task automatic test_loads();
    preload(0, 32'h12F45678);
    run_access(1'b1, 1'b0, 9'h002, 32'h0, F3_B, 1, "lb_0x002");
    n_checks++;
    if (rd_data !== 32'hFFFFFFF4) begin
      n_fail++;
      $display("FAIL lb_value: got %h want %h", rd_data, 32'hFFFFFFF4);
    end
    preload(0, 32'h80010000);
    run_access(1'b1, 1'b0, 9'h002, 32'h0, F3_HU, 0, "lhu_0x002");
    n_checks++;
    if (rd_data !== 32'h00008001) begin
      n_fail++;
      $display("FAIL lhu_value: got %h want %h", rd_data, 32'h00008001);
    end
  endtask

  task automatic test_misaligned_fault();
    run_access(1'b1, 1'b0, 9'h006, 32'h0, F3_W, 0, "lw_0x006");
    run_access(1'b0, 1'b1, 9'h008, 32'h1234, F3_BU, 0, "sbu_illegal");
    run_access(1'b1, 1'b0, 9'h009, 32'h0, F3_HU, 0, "lhu_odd");
    run_access(1'b1, 1'b0, 9'h00C, 32'h0, 3'b011, 0, "f3_011");
  endtask

  task automatic test_reset_abort();
    preload(1, 32'hCAFE0001);
    run_access(1'b1, 1'b0, 9'h004, 32'h0, F3_W, 0, "lw_pre_abort");
    @(negedge clk);
    mem_read = 1'b1; addr = 9'h008; func3 = F3_W; bus_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (bus_req !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_in_access: got bus_req=%b want 1", bus_req);
    end
    reset = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus_req !== 1'b0 || rd_data !== 32'd0 || mem_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset: got req=%b rd=%h stall=%b want req=0 rd=0 stall=0",
               bus_req, rd_data, mem_stall);
    end
    reset = 1'b1;
    exp_rd = '0;
    run_access(1'b1, 1'b0, 9'h004, 32'h0, F3_W, 1, "lw_after_abort");
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    run_access(1'b1, 1'b0, 9'h020, 32'h0, F3_W, 1000, "timeout_load");
    run_access(1'b1, 1'b0, 9'h004, 32'h0, F3_W, 15, "ack_at_limit");
  endtask
`else
  task automatic test_long_wait();
    run_access(1'b1, 1'b0, 9'h020, 32'h0, F3_W, 20, "long_wait_load");
  endtask
`endif

  task automatic test_random();
    int          kind, waits;
    logic [8:0]  a;
    logic [31:0] d;
    logic [2:0]  f3;
    for (int w = 0; w < 128; w++) preload(w, $urandom);
    for (int n = 0; n < 60; n++) begin
      kind  = $urandom_range(0, 2);
      a     = 9'($urandom);
      d     = $urandom;
      f3    = 3'($urandom);
      waits = $urandom_range(0, 3);
      run_access(kind != 1, kind != 0, a, d, f3, waits, "random");
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte_waits();
    test_loads();
    test_misaligned_fault();
    test_reset_abort();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage of the 5-stage pipeline.
- Consumes the EX/MEM register fields (MemRead, MemWrite, ALU-result address, forwarded store data, func3) and drives a word-wide memory bus with wait states.
- Returns aligned, sign- or zero-extended load data to the MEM/WB register.
- Asserts a stall that freezes the whole pipeline until the bus access completes.

Parameters:
- DM_ADDRESS, 9, byte address width.
- DATA_W, 32, data width; fixed at 32 because byte enables are 4 bits.
- TIMEOUT_CYC, 16, bus wait limit in cycles; used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- mem_read  in  1  load request from EX/MEM.
- mem_write  in  1  store request from EX/MEM.
- addr  in  DM_ADDRESS  byte address.
- wr_data  in  DATA_W  store data, right-aligned.
- func3  in  3  access size and sign.
- rd_data  out  DATA_W  extended load result.
- mem_stall  out  1  pipeline freeze.
- access_fault  out  1  one-cycle fault pulse.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write.
- bus_addr  out  DM_ADDRESS  word address, {addr[8:2], 2'b00}.
- bus_wdata  out  DATA_W  lane-replicated store data.
- bus_be  out  4  byte enables.
- bus_rdata  in  DATA_W  bus read data.
- bus_ack  in  1  bus access complete.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state goes to IDLE.
  - rd_data, bus_req, bus_we, bus_be, bus_addr, bus_wdata are cleared to 0.
  - access_fault goes to 0.
  - mem_stall goes to 0, apart from the IDLE combinational term below.
  - A reset during ACCESS aborts the transfer; bus_req is 0 from the next cycle.
- States are IDLE, ACCESS and DONE.
- IDLE:
  - If mem_read or mem_write is set and the access is legal, mem_stall=1 (combinational).
  - The request is registered (bus_addr, bus_we, bus_be, bus_wdata, func3, byte offset) and the state goes to ACCESS.
  - mem_write has priority when both requests are set.
- ACCESS:
  - bus_req=1 and mem_stall=1.
  - The bus outputs hold stable until bus_ack.
  - On bus_ack:
    - A load registers the extended bus_rdata into rd_data.
    - A store leaves rd_data unchanged.
    - The state goes to DONE.
- DONE:
  - bus_req=0 and mem_stall=0; the pipeline advances on this edge.
  - No new access starts from DONE.
  - The state always goes to IDLE next cycle.
- Minimum cost is 2 stall cycles per access, when bus_ack comes in the first ACCESS cycle. Each extra wait cycle adds 1.
- rd_data holds its value until the next load completes or a fault occurs.
- Access sizes (func3):
  - 000 LB/SB
  - 001 LH/SH
  - 010 LW/SW
  - 100 LBU
  - 101 LHU
- Illegal accesses are faulted:
  - any other func3;
  - a store with func3 100 or 101;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0.
- Fault handling:
  - No bus access and no stall.
  - access_fault pulses for 1 cycle; for a load, rd_data is set to 0.
  - The state stays IDLE.
- Store lanes:
  - SB: be = 1<<addr[1:0], wdata = {4{wr_data[7:0]}}.
  - SH: be = 0011 or 1100, wdata = {2{wr_data[15:0]}}.
  - SW: be = 1111.
- Load extraction:
  - Select the byte or halfword at the registered offset.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - For loads, bus_be is set to the access-size enables.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entering ACCESS and increments each ACCESS cycle without bus_ack.
  - When the counter reaches TIMEOUT_CYC-1 without bus_ack, the access aborts. access_fault pulses, a load sets rd_data=0, and the state goes to DONE.
  - bus_ack arriving in that same cycle wins.
- Undefined: there is no counter and ACCESS waits for bus_ack indefinitely.

Decomposition:
- lsu_pkg holds:
  - lsu_state_t enum (IDLE, ACCESS, DONE);
  - func3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
- One combinational sub-module, lsu_load_align: inputs bus_rdata, offset and func3; output is the extended data.

Test Plan:
- SW addr 0x010, data 0xDEADBEEF, ack in the first ACCESS cycle → bus_be=1111, bus_addr=0x010, mem_stall high exactly 2 cycles, rd_data unchanged.
- SB addr 0x013, data 0x000000A5, ack after 3 waits → bus_be=1000, bus_wdata=0xA5A5A5A5, mem_stall high 5 cycles.
- LB addr 0x002, bus_rdata 0x12F45678 → rd_data=0xFFFFFFF4. Then LHU addr 0x002, bus_rdata 0x8001_0000 → rd_data=0x00008001.
- LW addr 0x006 → access_fault 1-cycle pulse, rd_data=0, bus_req never 1, mem_stall stays 0.
- Reset driven low during ACCESS (no ack) → next cycle bus_req=0, rd_data=0, state IDLE. A following LW addr 0x004 completes normally.
- With LSU_TIMEOUT_EN, TIMEOUT_CYC=16, and a load that is never acked → fault pulse, rd_data=0, mem_stall released after ACCESS+DONE (18 cycles total).
